// File: rtl/modport_bridge.sv
// MAC RX stream to AFU AXI-S bridge with a packet-aware FIFO and overflow drop.
// Define MODPORT_BRIDGE_ERR_DROP_EN to discard packets flagged by s_tuser.
module modport_bridge #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_tvalid,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tuser,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tuser,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                drop_pulse
);

  localparam int KW = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + KW + 2;

  typedef logic [AW:0] ptr_t;
  typedef enum logic {ACCEPT, DROP} state_t;

  localparam ptr_t             DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t             PTR_ONE = ptr_t'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [EW-1:0] mem [DEPTH];
  ptr_t          wr_ptr;
  ptr_t          commit_ptr;
  ptr_t          rd_ptr;
  state_t        state;

  logic full;
  logic avail;
  logic acc;
  logic wr_en;
  logic ovf;
  logic err;
  logic rd_en;
  logic user_in;

  // full uses the registered rd_ptr: a same-cycle read frees nothing
  assign full  = (wr_ptr - rd_ptr) == DEPTH_P;
  assign avail = rd_ptr != commit_ptr;
  assign acc   = (state == ACCEPT) && s_tvalid;
  assign wr_en = acc && !full;
  assign ovf   = acc && full;
  assign rd_en = avail && m_tready;

`ifdef MODPORT_BRIDGE_ERR_DROP_EN
  assign err     = wr_en && s_tlast && s_tuser;
  assign user_in = 1'b0;
`else
  assign err     = 1'b0;
  assign user_in = s_tuser;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast, user_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      state      <= ACCEPT;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case (state)
        ACCEPT: begin
          if (ovf || err) begin
            wr_ptr     <= commit_ptr;
            drop_pulse <= 1'b1;
            if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + CNT_ONE;
            end
            if (ovf && !s_tlast) begin
              state <= DROP;
            end
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (s_tlast) begin
              commit_ptr <= wr_ptr + PTR_ONE;
            end
          end
        end
        DROP: begin
          if (s_tvalid && s_tlast) begin
            state <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign m_tvalid = avail;
  assign {m_tdata, m_tkeep, m_tlast, m_tuser} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_modport_bridge.sv
// Directed and random bench for modport_bridge.
// Reference model: queues of committed and pending packet beats.
module tb_modport_bridge;

  localparam int DEPTH = 16;
`ifdef MODPORT_BRIDGE_ERR_DROP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] drop_cnt;
  logic        drop_pulse;

  modport_bridge #(
    .DATA_W(64),
    .DEPTH (DEPTH),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .drop_cnt  (drop_cnt),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       out_q[$];
  beat_t       cur[$];
  bit          dropping;
  logic [15:0] m_cnt;
  bit          m_pulse;

  int checks = 0;
  int errors = 0;
  int n_out;
  int n_last;
  int n_pulse;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic note_drop();
    m_pulse = 1'b1;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_edge();
    bit    fire;
    int    occ;
    beat_t b;
    fire = (out_q.size() != 0) && m_tready;
    occ  = out_q.size() + cur.size();
    if (rst) begin
      out_q.delete();
      cur.delete();
      dropping = 1'b0;
      m_cnt    = '0;
      m_pulse  = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    if (s_tvalid) begin
      if (dropping) begin
        if (s_tlast) dropping = 1'b0;
      end else if (occ >= DEPTH) begin
        cur.delete();
        note_drop();
        if (!s_tlast) dropping = 1'b1;
      end else begin
        b.d = s_tdata;
        b.k = s_tkeep;
        b.l = s_tlast;
        b.u = ERR_EN ? 1'b0 : s_tuser;
        cur.push_back(b);
        if (s_tlast) begin
          if (ERR_EN && s_tuser) begin
            cur.delete();
            note_drop();
          end else begin
            foreach (cur[i]) out_q.push_back(cur[i]);
            cur.delete();
          end
        end
      end
    end
    if (fire) void'(out_q.pop_front());
  endtask

  task automatic compare();
    chk("m_tvalid", 64'(m_tvalid), 64'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      chk("m_tdata", m_tdata, out_q[0].d);
      chk("m_tkeep", 64'(m_tkeep), 64'(out_q[0].k));
      chk("m_tlast", 64'(m_tlast), 64'(out_q[0].l));
      chk("m_tuser", 64'(m_tuser), 64'(out_q[0].u));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    chk("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
  endtask

  task automatic step();
    if (m_tvalid && m_tready) begin
      n_out++;
      if (m_tlast) n_last++;
    end
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (drop_pulse) n_pulse++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    n_out   = 0;
    n_last  = 0;
    n_pulse = 0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [63:0] base,
                          input logic u);
    for (int i = 0; i < len; i++) begin
      send(base + 64'(i), 8'hFF, i == len - 1, u && (i == len - 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    clr();
  endtask

  initial begin
    int len;
    int pos;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b0;
    dropping = 1'b0;
    m_cnt    = '0;
    m_pulse  = 1'b0;
    clr();

    // reset state
    do_reset();
    chk("rst_vld", 64'(m_tvalid), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_pulse", 64'(drop_pulse), 64'd0);

    // normal 3-beat packet
    m_tready = 1'b1;
    send(64'h11, 8'hFF, 1'b0, 1'b0);
    send(64'h22, 8'hFF, 1'b0, 1'b0);
    chk("t2_no_early", 64'(m_tvalid), 64'd0);
    send(64'h33, 8'h0F, 1'b1, 1'b0);
    chk("t2_lat", 64'(m_tvalid), 64'd1);
    chk("t2_first", m_tdata, 64'h11);
    steps(4);
    chk("t2_beats", 64'(n_out), 64'd3);
    chk("t2_lasts", 64'(n_last), 64'd1);

    // overflow
    do_reset();
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(4, 64'(p * 16 + 'h100), 1'b0);
    chk("t3_cnt0", 64'(drop_cnt), 64'd0);
    send_pkt(2, 64'h200, 1'b0);
    chk("t3_cnt1", 64'(drop_cnt), 64'd1);
    chk("t3_pulses", 64'(n_pulse), 64'd1);
    m_tready = 1'b1;
    steps(20);
    chk("t3_beats", 64'(n_out), 64'd16);
    chk("t3_lasts", 64'(n_last), 64'd4);
    chk("t3_empty", 64'(m_tvalid), 64'd0);

    // oversize packet
    do_reset();
    m_tready = 1'b1;
    send_pkt(20, 64'h300, 1'b0);
    steps(2);
    chk("t4_none", 64'(n_out), 64'd0);
    chk("t4_cnt", 64'(drop_cnt), 64'd1);
    send_pkt(2, 64'h400, 1'b0);
    steps(4);
    chk("t4_beats", 64'(n_out), 64'd2);
    chk("t4_lasts", 64'(n_last), 64'd1);

    // errored packet
    do_reset();
    m_tready = 1'b1;
    send_pkt(2, 64'h500, 1'b1);
    steps(4);
    chk("t5_cnt", 64'(drop_cnt), ERR_EN ? 64'd1 : 64'd0);
    chk("t5_beats", 64'(n_out), ERR_EN ? 64'd0 : 64'd2);

    // reset mid-traffic
    do_reset();
    m_tready = 1'b0;
    send_pkt(2, 64'h600, 1'b0);
    for (int i = 0; i < 3; i++) send(64'h700 + 64'(i), 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_vld", 64'(m_tvalid), 64'd0);
    chk("t6_cnt", 64'(drop_cnt), 64'd0);
    m_tready = 1'b1;
    clr();
    send_pkt(1, 64'hAB, 1'b0);
    steps(3);
    chk("t6_beats", 64'(n_out), 64'd1);
    chk("t6_lasts", 64'(n_last), 64'd1);

    // random traffic against the model
    do_reset();
    len = 1;
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        if (pos == 0) begin
          len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(17, 22))
                                             : int'($urandom_range(1, 6));
        end
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tlast  = (pos == len - 1);
        s_tuser  = ($urandom_range(0, 3) == 0);
        pos      = (pos == len - 1) ? 0 : pos + 1;
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
      end
      step();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    steps(40);
    chk("rand_drain", 64'(m_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
